// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : key_conditioner
//  Description : Synchronises, debounces and edge-detects the push-button
//                keys into one-cycle press/release events. Synchronises the
//                slide switches and snapshots them on every accepted press.
//  Revision    : 1.0  initial release
// ============================================================================
module key_conditioner #(
  parameter int N_KEYS          = 2,
  parameter int N_SW            = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [N_KEYS-1:0] KEY,
  input  logic [N_SW-1:0]   SW,
  output logic [N_KEYS-1:0] KEY_DOWN,
  output logic [N_KEYS-1:0] KEY_PRESS,
  output logic [N_KEYS-1:0] KEY_RELEASE,
  output logic [N_SW-1:0]   SW_SYNC,
  output logic [N_SW-1:0]   SW_SNAP
);

  localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] r_key_meta;
  logic [N_KEYS-1:0] r_key_sync;
  logic [N_SW-1:0]   r_sw_meta;
  logic [N_SW-1:0]   r_sw_sync;
  logic [N_SW-1:0]   r_sw_snap;
  logic [N_KEYS-1:0] w_press_evt;   // key whose debounced level falls this edge

  // Two-flop synchronisers: keys idle high (released), switches idle low
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_key_meta <= '1;
      r_key_sync <= '1;
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
    end else begin
      r_key_meta <= KEY;
      r_key_sync <= r_key_meta;
      r_sw_meta  <= SW;
      r_sw_sync  <= r_sw_meta;
    end
  end

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_db;
    logic               r_press;
    logic               r_release;
    logic               w_diff;
    logic               w_done;

    // Sample disagrees with the accepted level; the run completes on the last count
    assign w_diff         = r_key_sync[gi] ^ r_db;
    assign w_done         = w_diff && (r_cnt == c_CNT_LAST);
    assign w_press_evt[gi] = w_done & r_db;

    // Debounce counter and accepted level; pulses registered with the level change
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        r_cnt     <= '0;
        r_db      <= 1'b1;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= w_done & r_db;
        r_release <= w_done & ~r_db;
        if (!w_diff) begin
          r_cnt <= '0;
        end else if (w_done) begin
          r_db  <= r_key_sync[gi];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_CNT_W'(1);
        end
      end
    end

    assign KEY_DOWN[gi]    = ~r_db;
    assign KEY_PRESS[gi]   = r_press;
    assign KEY_RELEASE[gi] = r_release;
  end

  // Capture the synchronised switches once on any accepted press
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sw_snap <= '0;
    end else if (|w_press_evt) begin
      r_sw_snap <= r_sw_sync;
    end
  end

  assign SW_SYNC = r_sw_sync;
  assign SW_SNAP = r_sw_snap;

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_conditioner
//  Description : Randomised and directed stimulus for key_conditioner with a
//                window-based reference model feeding an event scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_conditioner;

  localparam int N_KEYS = 2;
  localparam int N_SW   = 4;
  localparam int D      = 4;

  logic              CLOCK_50;
  logic              RESET_N;
  logic [N_KEYS-1:0] KEY;
  logic [N_SW-1:0]   SW;
  logic [N_KEYS-1:0] KEY_DOWN;
  logic [N_KEYS-1:0] KEY_PRESS;
  logic [N_KEYS-1:0] KEY_RELEASE;
  logic [N_SW-1:0]   SW_SYNC;
  logic [N_SW-1:0]   SW_SNAP;

  key_conditioner #(
    .N_KEYS          (N_KEYS),
    .N_SW            (N_SW),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .KEY         (KEY),
    .SW          (SW),
    .KEY_DOWN    (KEY_DOWN),
    .KEY_PRESS   (KEY_PRESS),
    .KEY_RELEASE (KEY_RELEASE),
    .SW_SYNC     (SW_SYNC),
    .SW_SNAP     (SW_SNAP)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int                cyc;
    logic [N_KEYS-1:0] p;
    logic [N_KEYS-1:0] r;
    logic [N_SW-1:0]   s;
  } ev_t;

  ev_t sbq[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  cyc      = 0;

  // Reference model state: a two-sample input delay, the last D key samples,
  // the accepted key levels and the last switch snapshot.
  logic [N_KEYS-1:0] m_k_sync = '1, m_k_meta = '1;
  logic [N_SW-1:0]   m_s_sync = '0, m_s_meta = '0;
  logic [N_KEYS-1:0] hist[$];
  logic [N_KEYS-1:0] m_down = '0;
  logic [N_SW-1:0]   m_snap = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: a key level is accepted once the last D synchronised
  // samples all show the opposite level; events go to the scoreboard.
  always @(posedge CLOCK_50 or negedge RESET_N) begin : model
    logic [N_KEYS-1:0] ks;
    logic [N_SW-1:0]   sws;
    logic [N_KEYS-1:0] p, r;
    bit                all0, all1;
    if (!RESET_N) begin
      m_k_sync = '1; m_k_meta = '1;
      m_s_sync = '0; m_s_meta = '0;
      hist.delete();
      m_down = '0;
      m_snap = '0;
      sbq.delete();
      if (CLOCK_50) cyc++;
    end else begin
      cyc++;
      ks  = m_k_sync;
      sws = m_s_sync;
      m_k_sync = m_k_meta; m_k_meta = KEY;
      m_s_sync = m_s_meta; m_s_meta = SW;
      hist.push_back(ks);
      if (hist.size() > D) void'(hist.pop_front());
      p = '0;
      r = '0;
      if (hist.size() == D) begin
        for (int i = 0; i < N_KEYS; i++) begin
          all0 = 1'b1;
          all1 = 1'b1;
          for (int j = 0; j < D; j++) begin
            if (hist[j][i]) all0 = 1'b0;
            else            all1 = 1'b0;
          end
          if (!m_down[i] && all0) begin
            m_down[i] = 1'b1;
            p[i] = 1'b1;
          end else if (m_down[i] && all1) begin
            m_down[i] = 1'b0;
            r[i] = 1'b1;
          end
        end
      end
      if (p != '0) m_snap = sws;
      if ((p | r) != '0) sbq.push_back('{cyc: cyc, p: p, r: r, s: m_snap});
    end
  end

  // Monitor: level outputs every cycle, pulse outputs against the scoreboard
  always @(negedge CLOCK_50) begin : monitor
    ev_t e;
    chk("key_down", KEY_DOWN, m_down);
    chk("sw_sync",  SW_SYNC,  m_s_sync);
    chk("sw_snap",  SW_SNAP,  m_snap);
    if ((KEY_PRESS | KEY_RELEASE) != '0) begin
      if (sbq.size() == 0) begin
        chk("spurious_pulse", {KEY_PRESS, KEY_RELEASE}, 32'h0);
      end else begin
        e = sbq.pop_front();
        chk("event_cycle",  cyc, e.cyc);
        chk("event_pulses", {KEY_PRESS, KEY_RELEASE}, {e.p, e.r});
        chk("event_snap",   SW_SNAP, e.s);
      end
    end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      chk("missed_event", {KEY_PRESS, KEY_RELEASE}, {e.p, e.r});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #2;
    end
  endtask

  initial begin
    RESET_N = 1'b0;
    KEY     = 2'b11;
    SW      = 4'b0000;
    tick(3);
    RESET_N = 1'b1;

    // Idle: no events, all outputs zero
    tick(20);

    // Clean press and release of KEY[0]
    KEY[0] = 1'b0; tick(10);
    KEY[0] = 1'b1; tick(10);

    // Bouncing KEY[1], then a solid hold
    KEY[1] = 1'b0; tick(3);
    KEY[1] = 1'b1; tick(1);
    KEY[1] = 1'b0; tick(3);
    KEY[1] = 1'b1; tick(8);
    KEY[1] = 1'b0; tick(6);
    KEY[1] = 1'b1; tick(10);

    // Switch snapshot follows the press, not later switch changes
    SW = 4'b0110; tick(3);
    KEY[0] = 1'b0; tick(8);
    SW = 4'b1001;  tick(5);
    KEY[0] = 1'b1; tick(8);
    KEY[1] = 1'b0; tick(8);
    KEY[1] = 1'b1; tick(8);

    // Simultaneous presses
    SW  = 4'b0011;
    KEY = 2'b00; tick(8);
    KEY = 2'b11; tick(8);

    // Reset mid-count with KEY[0] held through reset release
    KEY[0]  = 1'b0; tick(2);
    RESET_N = 1'b0; tick(2);
    RESET_N = 1'b1; tick(10);
    KEY[0]  = 1'b1; tick(10);

    // Randomised activity with occasional resets
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 39) == 0) begin
        RESET_N = 1'b0;
        tick($urandom_range(1, 2));
        RESET_N = 1'b1;
      end
      KEY = 2'($urandom_range(0, 3));
      SW  = 4'($urandom_range(0, 15));
      tick($urandom_range(1, 8));
    end

    KEY = 2'b11;
    tick(14);
    chk("scoreboard_drained", sbq.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
